// File: rtl/io_port.sv
// Memory-mapped I/O port at addresses 30 (input FIFO) and 31 (output register / status).
// Define IO_IRQ_EN to add a registered interrupt output `irq`.
module io_port #(
  parameter int WORD_W     = 8,
  parameter int OP_W       = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              MDR_bus,
  input  logic              load_MDR,
  input  logic              load_MAR,
  input  logic              CS,
  input  logic              R_NW,
  inout  wire  [WORD_W-1:0] sysbus,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef IO_IRQ_EN
  , output logic            irq
`endif
);

  localparam int AW = WORD_W - OP_W;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [AW-1:0] ADDR_IN  = AW'(30);
  localparam logic [AW-1:0] ADDR_OUT = AW'(31);

  logic [AW-1:0]     mar_q, mar_d;
  logic [WORD_W-1:0] mdr_q, mdr_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q, overrun_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];

  logic              mapped, access;
  logic              rd_in, rd_stat, wr_out;
  logic              empty, full, push, pop;
  logic              handshake, wr_accept;
  logic [WORD_W-1:0] status;

  assign mapped    = (mar_q == ADDR_IN) | (mar_q == ADDR_OUT);
  // An access only happens on edges where neither MAR nor MDR is being loaded.
  assign access    = CS & mapped & ~load_MAR & ~load_MDR;
  assign rd_in     = access & R_NW & (mar_q == ADDR_IN);
  assign rd_stat   = access & R_NW & (mar_q == ADDR_OUT);
  assign wr_out    = access & ~R_NW & (mar_q == ADDR_OUT);

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign in_ready  = ~full & ~reset;
  assign push      = in_valid & in_ready;
  assign pop       = rd_in & ~empty;

  assign handshake = out_valid_q & out_ready;
  assign wr_accept = wr_out & (~out_valid_q | out_ready);

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sysbus    = (MDR_bus & mapped) ? mdr_q : {WORD_W{1'bz}};

  always_comb begin
    status      = '0;
    status[7]   = out_valid_q;
    status[6]   = overrun_q;
    status[5]   = full;
    status[4]   = empty;
    status[3:0] = 4'(count_q);
  end

  always_comb begin
    mar_d       = mar_q;
    mdr_d       = mdr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    if (load_MAR) begin
      mar_d = sysbus[AW-1:0];
    end else if (load_MDR) begin
      mdr_d = sysbus;
    end else if (rd_in) begin
      mdr_d = empty ? '0 : mem_q[rd_ptr_q];
    end else if (rd_stat) begin
      mdr_d = status;
    end

    // A write accepted on the handshake edge keeps out_valid high with the new data.
    if (wr_accept) begin
      out_data_d  = mdr_q;
      out_valid_d = 1'b1;
    end else if (handshake) begin
      out_valid_d = 1'b0;
    end

    if (rd_stat) begin
      overrun_d = 1'b0;
    end else if (wr_out && !wr_accept) begin
      overrun_d = 1'b1;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mar_q       <= '0;
      mdr_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      mar_q       <= mar_d;
      mdr_q       <= mdr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

`ifdef IO_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_q;
    if (~empty | (handshake & ~wr_accept)) begin
      irq_d = 1'b1;
    end else if (rd_stat) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_io_port.sv
// Self-checking bench for io_port: bus reads are scored against an expectation queue.
module tb_io_port;

  logic        clock = 1'b0;
  logic        reset;
  logic        MDR_bus, load_MDR, load_MAR, CS, R_NW;
  wire  [7:0]  sysbus;
  logic [7:0]  busDrv;
  logic        busEn;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef IO_IRQ_EN
  logic        irq;
`endif

  int          checkCount = 0;
  int          passCount  = 0;
  logic [7:0]  expQ[$];
  logic        busIdle;

  assign sysbus = busEn ? busDrv : 8'hzz;

  io_port #(.WORD_W(8), .OP_W(3), .FIFO_DEPTH(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .MDR_bus  (MDR_bus),
    .load_MDR (load_MDR),
    .load_MAR (load_MAR),
    .CS       (CS),
    .R_NW     (R_NW),
    .sysbus   (sysbus),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef IO_IRQ_EN
    , .irq    (irq)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setMar(input logic [4:0] addr);
    busDrv   = {3'b000, addr};
    busEn    = 1'b1;
    load_MAR = 1'b1;
    tick();
    load_MAR = 1'b0;
    busEn    = 1'b0;
  endtask

  task automatic loadMdr(input logic [7:0] d);
    busDrv   = d;
    busEn    = 1'b1;
    load_MDR = 1'b1;
    tick();
    load_MDR = 1'b0;
    busEn    = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic readReg(input string tag, input logic [4:0] addr, input logic [7:0] expected,
                         input logic pushEn, input logic [7:0] pushData);
    expQ.push_back(expected);
    setMar(addr);
    CS       = 1'b1;
    R_NW     = 1'b1;
    in_valid = pushEn;
    in_data  = pushData;
    tick();
    CS       = 1'b0;
    in_valid = 1'b0;
    MDR_bus  = 1'b1;
    #1;
    checkOutput(tag, sysbus, expQ.pop_front());
    MDR_bus  = 1'b0;
  endtask

  task automatic writeReg(input logic [4:0] addr, input logic [7:0] d, input logic readyAtWrite);
    setMar(addr);
    loadMdr(d);
    CS        = 1'b1;
    R_NW      = 1'b0;
    out_ready = readyAtWrite;
    tick();
    CS        = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    MDR_bus = 1'b0; load_MDR = 1'b0; load_MAR = 1'b0; CS = 1'b0; R_NW = 1'b0;
    busDrv = 8'h00; busEn = 1'b0;
    in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;

    #12;
    checkOutput("rst_in_ready", 8'(in_ready), 8'h00);
    checkOutput("rst_out_valid", 8'(out_valid), 8'h00);
    checkOutput("rst_out_data", out_data, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    tick();
    checkOutput("post_rst_in_ready", 8'(in_ready), 8'h01);
    readReg("rst_status", 5'd31, 8'h10, 1'b0, 8'h00);

    // Reset in the middle of a transfer with three entries queued and output pending
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    writeReg(5'd31, 8'h11, 1'b0);
    checkOutput("pre_rst_out_valid", 8'(out_valid), 8'h01);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_out_valid", 8'(out_valid), 8'h00);
    checkOutput("async_rst_in_ready", 8'(in_ready), 8'h00);
    tick();
    @(negedge clock);
    reset = 1'b0;
    tick();
    readReg("midrst_status", 5'd31, 8'h10, 1'b0, 8'h00);
    checkOutput("midrst_out_data", out_data, 8'h00);

    // Basic FIFO reads through the bus
    applyStimulus(8'hA1);
    applyStimulus(8'hB2);
    readReg("fifo_rd_a1", 5'd30, 8'hA1, 1'b0, 8'h00);
    readReg("fifo_rd_b2", 5'd30, 8'hB2, 1'b0, 8'h00);
    readReg("fifo_rd_empty", 5'd30, 8'h00, 1'b0, 8'h00);
    readReg("empty_status", 5'd31, 8'h10, 1'b0, 8'h00);

    // Fill to capacity across the pointer wrap, then overfill
    for (int i = 1; i <= 4; i++) applyStimulus(8'(i));
    checkOutput("full_in_ready", 8'(in_ready), 8'h00);
    readReg("full_status", 5'd31, 8'h24, 1'b0, 8'h00);
    applyStimulus(8'h05);
    readReg("fifth_dropped_status", 5'd31, 8'h24, 1'b0, 8'h00);
    readReg("pop_01", 5'd30, 8'h01, 1'b0, 8'h00);
    checkOutput("pop_in_ready", 8'(in_ready), 8'h01);
    for (int i = 2; i <= 4; i++) readReg("drain", 5'd30, 8'(i), 1'b0, 8'h00);
    readReg("drain_empty", 5'd30, 8'h00, 1'b0, 8'h00);

    // Concurrent push and pop, non-empty and empty cases
    applyStimulus(8'hC1);
    readReg("pushpop_c1", 5'd30, 8'hC1, 1'b1, 8'hC2);
    readReg("pushpop_status", 5'd31, 8'h01, 1'b0, 8'h00);
    readReg("pushpop_c2", 5'd30, 8'hC2, 1'b0, 8'h00);
    readReg("empty_pushpop", 5'd30, 8'h00, 1'b1, 8'hD5);
    readReg("no_bypass_d5", 5'd30, 8'hD5, 1'b0, 8'h00);

    // Output register overrun
    writeReg(5'd31, 8'h5C, 1'b0);
    checkOutput("wr_out_valid", 8'(out_valid), 8'h01);
    checkOutput("wr_out_data", out_data, 8'h5C);
    writeReg(5'd31, 8'h77, 1'b0);
    checkOutput("overrun_out_data", out_data, 8'h5C);
    readReg("overrun_status", 5'd31, 8'hD0, 1'b0, 8'h00);
    readReg("overrun_cleared", 5'd31, 8'h90, 1'b0, 8'h00);

    // Write accepted on the same edge as the handshake
    writeReg(5'd31, 8'h3E, 1'b1);
    checkOutput("same_edge_out_valid", 8'(out_valid), 8'h01);
    checkOutput("same_edge_out_data", out_data, 8'h3E);
    readReg("same_edge_status", 5'd31, 8'h90, 1'b0, 8'h00);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("handshake_out_valid", 8'(out_valid), 8'h00);

    // Unmapped address 29
    setMar(5'd29);
    loadMdr(8'hC3);
    MDR_bus = 1'b1;
    #1;
    busIdle = (sysbus === 8'hzz) || (sysbus === 8'h00);
    checkOutput("unmapped_bus_idle", 8'(busIdle), 8'h01);
    MDR_bus = 1'b0;
    CS = 1'b1;
    R_NW = 1'b0;
    tick();
    CS = 1'b0;
    checkOutput("unmapped_out_valid", 8'(out_valid), 8'h00);
    checkOutput("unmapped_out_data", out_data, 8'h3E);
    readReg("unmapped_status", 5'd31, 8'h10, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/io_port.md
# io_port

Memory-mapped I/O port for the basic processor, sharing `sysbus` and the RAM control strobes (`load_MAR`, `load_MDR`, `CS`, `R_NW`, `MDR_bus`). It decodes the two top addresses, 30 and 31, which the RAM leaves unmapped. Address 30 is an input FIFO fed by an external producer. Address 31 is an output register with a valid/ready handshake on writes and a status word on reads.

## Interface
- `WORD_W`, default 8: data/bus width.
- `OP_W`, default 3: opcode width; the address is `WORD_W-OP_W` bits (5).
- `FIFO_DEPTH`, default 4: input FIFO entries, power of two, 2..8.

Ports:
- `clock` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `MDR_bus` input 1: drive local MDR onto `sysbus` when mapped.
- `load_MDR` input 1: latch `sysbus` into local MDR.
- `load_MAR` input 1: latch `sysbus[WORD_W-OP_W-1:0]` into local MAR.
- `CS` input 1: access strobe.
- `R_NW` input 1: 1 = read into MDR, 0 = write from MDR.
- `sysbus` inout WORD_W: shared bus, tri-stated when not driving.
- `in_data` input WORD_W: producer data.
- `in_valid` input 1: producer data valid.
- `in_ready` output 1: FIFO can accept data.
- `out_data` output WORD_W: output register.
- `out_valid` output 1: `out_data` pending.
- `out_ready` input 1: consumer accepts `out_data`.

## Operation
- `mapped` = (mar == 30) | (mar == 31).
- Register priority per clock edge is `load_MAR`, then `load_MDR`, then `CS`.
  - `load_MAR`: mar <= sysbus[4:0].
  - `load_MDR`: mdr <= sysbus.
  - `CS & mapped`: perform the access below.
- `sysbus` = mdr when `MDR_bus & mapped`, else all Z.
- Read at 30 (`CS & R_NW`):
  - FIFO non-empty: mdr <= head, pop.
  - Empty: mdr <= 0, no pop.
- Write at 30: ignored.
- Read at 31: mdr <= status.
  - bit7 `out_valid`, bit6 `overrun`, bit5 `full`, bit4 `empty`, bits3:0 `count`.
  - Clears `overrun` at the same edge.
- Write at 31:
  - `out_valid` low, or the handshake completes this cycle: out_data <= mdr, `out_valid` <= 1.
  - Otherwise: data dropped, `overrun` <= 1.
- Output handshake: `out_valid & out_ready` at an edge clears `out_valid`, unless a write to 31 is accepted at that same edge, in which case `out_valid` stays 1 with the new data.
- Input FIFO:
  - `in_ready` = ~full & ~reset.
  - Push on `in_valid & in_ready` at the edge.
  - Circular buffer with wrap-around read/write pointers and a `count` of width log2(FIFO_DEPTH)+1.
- Simultaneous push and pop with non-empty FIFO: both happen, `count` unchanged.
- Push into an empty FIFO while a pop is requested: the pop sees empty and returns 0, no bypass. The pushed word is stored.

## Timing
- Reset values: mar 0, mdr 0, `out_data` 0, `out_valid` 0, `overrun` 0, FIFO empty with pointers 0, `in_ready` 0 while `reset` is high and 1 after, `sysbus` Z.
- Reset mid-operation discards FIFO contents and any pending output immediately. `out_valid` falls asynchronously.
- Push: the entry is visible in `count` and `empty` from the next cycle.
- Read latency: access edge, then mdr valid; drivable on `sysbus` from the following cycle via `MDR_bus`.
- Write: `out_valid` rises one edge after the `CS` write cycle.
- `in_ready` falls the cycle after the push that fills the FIFO, and rises the cycle after the pop that frees an entry.
- Unmapped addresses (mar < 30): no state change, no bus drive.

## Configuration
- `IO_IRQ_EN` defined:
  - Adds output `irq` (1 bit, reset 0), registered.
  - `irq` is 1 the cycle after the FIFO is non-empty or `out_valid` falls via handshake.
  - Stays high until a status read at address 31.
- `IO_IRQ_EN` undefined: no `irq` port, no related logic.

## Test plan
- Reset asserted mid-transfer with 3 entries queued and `out_valid`=1:
  - Immediately: `out_valid`=0, `in_ready`=0.
  - After release: status read = 8'h10.
- Push 8'hA1, 8'hB2 via `in_valid`; read address 30 twice with `MDR_bus`:
  - `sysbus` shows A1 then B2.
  - Third read shows 00, status bit4=1.
- Push 4 words with `out_ready`=0:
  - `in_ready`=0, status = 8'h24.
  - A 5th `in_valid` is not stored.
  - One pop: `in_ready`=1 the next cycle.
- Write 8'h5C to 31 with `out_ready`=0, then write 8'h77:
  - `out_data` stays 5C, status = 8'hD0.
  - A second status read shows bit6=0.
- Same-edge handshake and write of 8'h3E:
  - `out_valid` stays 1, `out_data`=3E.
- Address 29 with `MDR_bus`=1: `sysbus` stays Z; `CS` writes have no effect.
